// File: rtl/bcd_up_timer.sv
// MM:SS elapsed-time counter in BCD with a one-second prescaler, an optional
// BCD stop limit and a start/stop/clear command FSM.
module bcd_up_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic [15:0] limit,
  output logic [3:0]  sec_units,
  output logic [3:0]  sec_tens,
  output logic [3:0]  min_units,
  output logic [3:0]  min_tens,
  output logic        running,
  output logic        done,
  output logic        tick
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_pre;
  logic [15:0]      r_cnt;    // {min_tens, min_units, sec_tens, sec_units}
  logic [15:0]      r_limit;
  logic             r_tick;
  logic             r_running;
  logic             r_done;

  logic [15:0]      w_inc;
  logic             w_c0, w_c1, w_c2;
  logic             w_tc;
  logic             w_hit;

  // Single-cycle BCD carry chain; 59:59 wraps to 00:00.
  always_comb begin
    w_inc        = r_cnt;
    w_c0         = (r_cnt[3:0] == 4'd9);
    w_c1         = w_c0 && (r_cnt[7:4] == 4'd5);
    w_c2         = w_c1 && (r_cnt[11:8] == 4'd9);
    w_inc[3:0]   = w_c0 ? 4'd0 : r_cnt[3:0] + 4'd1;
    if (w_c0) w_inc[7:4]   = (r_cnt[7:4] == 4'd5)   ? 4'd0 : r_cnt[7:4] + 4'd1;
    if (w_c1) w_inc[11:8]  = (r_cnt[11:8] == 4'd9)  ? 4'd0 : r_cnt[11:8] + 4'd1;
    if (w_c2) w_inc[15:12] = (r_cnt[15:12] == 4'd5) ? 4'd0 : r_cnt[15:12] + 4'd1;
  end

  // The incremented value is always legal BCD, so a malformed limit never matches.
  assign w_tc  = (r_pre == CNT_W'(TICK_DIV - 1));
  assign w_hit = (r_limit != 16'h0000) && (w_inc == r_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pre     <= '0;
      r_cnt     <= '0;
      r_limit   <= '0;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pre <= '0;
          if (clear) begin
            r_cnt <= '0;
          end else if (!stop && start) begin
            r_state   <= S_RUN;
            r_limit   <= limit;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (clear) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pre     <= '0;
            r_running <= 1'b0;
          end else if (stop) begin
            // Prescaler held so a resume finishes the partial second.
            r_state   <= S_PAUSE;
            r_running <= 1'b0;
          end else if (w_tc) begin
            r_pre  <= '0;
            r_tick <= 1'b1;
            r_cnt  <= w_inc;
            if (w_hit) begin
              r_state   <= S_DONE;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end
          end else begin
            r_pre <= r_pre + 1'b1;
          end
        end
        S_PAUSE: begin
          if (clear) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pre   <= '0;
          end else if (!stop && start) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_DONE: begin
          if (clear) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pre   <= '0;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign sec_units = r_cnt[3:0];
  assign sec_tens  = r_cnt[7:4];
  assign min_units = r_cnt[11:8];
  assign min_tens  = r_cnt[15:12];
  assign running   = r_running;
  assign done      = r_done;
  assign tick      = r_tick;

endmodule
